// File: rtl/motor_duty_ramp.sv
// motor_duty_ramp
//   Slew-rate limiter and direction sequencer placed in front of the 8-bit
//   PWM generator. A signed speed command is latched, and the unsigned duty
//   walks toward its magnitude by at most STEP every STEP_DIV clocks. A change
//   of direction is never made at non-zero duty: the duty is ramped to zero,
//   the bridge is braked for DEAD_TICKS ramp ticks, and only then does the
//   direction line flip.
//
// Parameters
//   STEP_DIV   clocks per ramp tick (>= 2)
//   STEP       maximum duty change per ramp tick (1..255)
//   DEAD_TICKS ramp ticks of braking at zero duty before a reversal (>= 1)
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   cmd        signed speed command (two's complement, -256..255, + = forward)
//   cmd_vld    single-cycle strobe, cmd sampled when high
//   estop      emergency stop (only when DUTY_RAMP_ESTOP_EN is defined)
//   duty       unsigned duty to the PWM generator
//   fwd        bridge direction, 1 = forward
//   brake      bridge brake, high during the reversal dead time
//   at_target  duty and direction match the latched command
//
// Optional feature
//   Define DUTY_RAMP_ESTOP_EN to add the estop input. While estop is high the
//   duty is forced to zero with the brake applied and the dead counter frozen;
//   when it falls the block resumes in RUN and ramps up from zero.

module motor_duty_ramp #(
  parameter int STEP_DIV   = 256,
  parameter int STEP       = 4,
  parameter int DEAD_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] cmd,
  input  logic       cmd_vld,
`ifdef DUTY_RAMP_ESTOP_EN
  input  logic       estop,
`endif
  output logic [7:0] duty,
  output logic       fwd,
  output logic       brake,
  output logic       at_target
);

  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_DIV - 1);
  localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_TICKS);
  localparam logic [8:0]    STEP9     = 9'(STEP);
  localparam logic [7:0]    STEP8     = 8'(STEP);

  // ST_ESTOP_HOLD is only ever entered when the estop feature is built in.
  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_REV_DECEL  = 2'd1,
    ST_REV_DEAD   = 2'd2,
    ST_ESTOP_HOLD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      duty_q, duty_d;
  logic            fwd_q, fwd_d;
  logic            brake_q, brake_d;
  logic            at_target_q, at_target_d;
  logic [7:0]      tgt_mag_q, tgt_mag_d;
  logic            tgt_fwd_q, tgt_fwd_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;

  logic            tick;
  logic            want_rev;
  logic [8:0]      cmd_neg;
  logic [7:0]      cmd_mag;
  logic            cmd_dir;
  logic [8:0]      diff_up;
  logic [8:0]      diff_dn;
  logic [8:0]      duty_up9;
  logic [7:0]      ramp_val;
  logic [7:0]      dec_val;
  logic [7:0]      decel_duty;

  assign tick     = (presc_q == PRESC_MAX);
  assign want_rev = (tgt_mag_q != 8'd0) && (tgt_fwd_q != fwd_q);

  // Command decode: magnitude with -256 clamped to 255, and a zero command
  // keeps the current direction so that it can never start a reversal.
  always_comb begin
    cmd_neg = (~cmd) + 9'd1;
    cmd_mag = 8'd0;
    if (cmd[8]) begin
      cmd_mag = cmd_neg[8] ? 8'hFF : cmd_neg[7:0];
    end else begin
      cmd_mag = cmd[7:0];
    end
    cmd_dir = (cmd == 9'd0) ? fwd_q : ~cmd[8];
  end

  // Candidate duty values. Differences are taken in 9 bits so the step can
  // clip exactly at the target without overshoot or wrap-around.
  always_comb begin
    diff_up  = {1'b0, tgt_mag_q} - {1'b0, duty_q};
    diff_dn  = {1'b0, duty_q} - {1'b0, tgt_mag_q};
    duty_up9 = {1'b0, duty_q} + STEP9;
    ramp_val = duty_q;
    if (duty_q < tgt_mag_q) begin
      ramp_val = (diff_up <= STEP9) ? tgt_mag_q : duty_up9[7:0];
    end else if (duty_q > tgt_mag_q) begin
      ramp_val = (diff_dn <= STEP9) ? tgt_mag_q : (duty_q - STEP8);
    end
    dec_val    = ({1'b0, duty_q} <= STEP9) ? 8'd0 : (duty_q - STEP8);
    decel_duty = tick ? dec_val : duty_q;
  end

  // Next-state logic. The FSM acts on the targets registered before this
  // edge, so a command arriving together with a tick only counts from the
  // following tick.
  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    fwd_d      = fwd_q;
    brake_d    = brake_q;
    dead_cnt_d = dead_cnt_q;
    presc_d    = tick ? '0 : (presc_q + PW'(1));
    tgt_mag_d  = tgt_mag_q;
    tgt_fwd_d  = tgt_fwd_q;

    if (cmd_vld) begin
      tgt_mag_d = cmd_mag;
      tgt_fwd_d = cmd_dir;
    end

    case (state_q)
      ST_RUN: begin
        if (want_rev) begin
          state_d = ST_REV_DECEL;
        end else if (tick) begin
          duty_d = ramp_val;
        end
      end

      ST_REV_DECEL: begin
        if (!want_rev) begin
          state_d = ST_RUN;
          if (tick) begin
            duty_d = ramp_val;
          end
        end else begin
          duty_d = decel_duty;
          if (decel_duty == 8'd0) begin
            state_d    = ST_REV_DEAD;
            brake_d    = 1'b1;
            dead_cnt_d = '0;
          end
        end
      end

      ST_REV_DEAD: begin
        duty_d = 8'd0;
        if (!want_rev) begin
          state_d = ST_RUN;
          brake_d = 1'b0;
          if (tick) begin
            duty_d = ramp_val;
          end
        end else if (dead_cnt_q == DEAD_MAX) begin
          state_d = ST_RUN;
          brake_d = 1'b0;
          fwd_d   = ~fwd_q;
        end else if (tick) begin
          dead_cnt_d = dead_cnt_q + DW'(1);
        end
      end

      default: begin
        // Leaving the estop hold: restart from zero duty in RUN.
        state_d = ST_RUN;
        brake_d = 1'b0;
        duty_d  = 8'd0;
      end
    endcase

`ifdef DUTY_RAMP_ESTOP_EN
    // Emergency stop overrides the sequencer; only the command latch and the
    // prescaler keep running, and the dead counter holds its value.
    if (estop) begin
      state_d    = ST_ESTOP_HOLD;
      duty_d     = 8'd0;
      brake_d    = 1'b1;
      fwd_d      = fwd_q;
      dead_cnt_d = dead_cnt_q;
    end
`endif

    at_target_d = (state_d == ST_RUN) && (duty_d == tgt_mag_d) &&
                  ((tgt_mag_d == 8'd0) || (tgt_fwd_d == fwd_d));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      duty_q      <= 8'd0;
      fwd_q       <= 1'b1;
      brake_q     <= 1'b0;
      at_target_q <= 1'b1;
      tgt_mag_q   <= 8'd0;
      tgt_fwd_q   <= 1'b1;
      presc_q     <= '0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      fwd_q       <= fwd_d;
      brake_q     <= brake_d;
      at_target_q <= at_target_d;
      tgt_mag_q   <= tgt_mag_d;
      tgt_fwd_q   <= tgt_fwd_d;
      presc_q     <= presc_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  assign duty      = duty_q;
  assign fwd       = fwd_q;
  assign brake     = brake_q;
  assign at_target = at_target_q;

endmodule
